// File: rtl/icc_ctrl_if.sv
// icc_ctrl_if: execute-stage <-> condition-code controller bus.
//
// Handshakes:
//   op:     an op transfers in a cycle where op_valid and op_ready are both 1.
//   branch: br_req is held with a stable br_cond until br_ack; br_ack is a
//           one-cycle pulse carrying br_taken, and no new request is
//           accepted in the br_ack cycle.
// dbg_state / dbg_wait_cnt expose the controller FSM for observation.
interface icc_ctrl_if;
  logic       op_valid;
  logic       op_setcc;
  logic       op_multi;
  logic       op_ready;
  logic       alu_done;
  logic [3:0] alu_flags;
  logic [3:0] fr_flags;
  logic       fr_ld;
  logic       cc_pending;
  logic       br_req;
  logic [3:0] br_cond;
  logic       br_ack;
  logic       br_taken;
  logic       stall;
  logic       cc_timeout;
  logic       dbg_state;
  logic [7:0] dbg_wait_cnt;

  // Execute stage / environment side
  modport master (
    output op_valid, op_setcc, op_multi, alu_done, alu_flags, fr_flags,
           br_req, br_cond,
    input  op_ready, fr_ld, cc_pending, br_ack, br_taken, stall, cc_timeout,
           dbg_state, dbg_wait_cnt
  );

  // Controller side
  modport slave (
    input  op_valid, op_setcc, op_multi, alu_done, alu_flags, fr_flags,
           br_req, br_cond,
    output op_ready, fr_ld, cc_pending, br_ack, br_taken, stall, cc_timeout,
           dbg_state, dbg_wait_cnt
  );
endinterface

// File: rtl/icc_ctrl.sv
// icc_ctrl: SPARC condition-code controller. Sequences loads of the 4-bit
// flag register {N,Z,V,C}, tracks pending flag writes (including multi-cycle
// ALU ops with a MAX_WAIT abandonment timer) and evaluates Bicc conditions,
// stalling a branch until the flags it depends on are committed.
// Optional feature macro: ICC_FORWARD_EN -- forwards alu_flags to a branch
// arriving in the same cycle as an FR load, removing that stall.
module icc_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  icc_ctrl_if.slave  bus
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ALU = 1'b1
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t     r_state;
  logic [7:0] r_wait_cnt;
  logic       r_br_ack;
  logic       r_br_taken;
  logic       r_cc_timeout;

  logic       w_fr_ld;
  logic       w_cc_pending;
  logic       w_br_accept;
  logic [3:0] w_eval_flags;
  logic       w_cond_true;

  // Bicc condition: cond[3] inverts the base test selected by cond[2:0]
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, v, c, base;
    {n, z, v, c} = f;
    case (cond[2:0])
      3'd0:    base = 1'b0;
      3'd1:    base = z;
      3'd2:    base = z | (n ^ v);
      3'd3:    base = n ^ v;
      3'd4:    base = c | z;
      3'd5:    base = c;
      3'd6:    base = n;
      default: base = v;
    endcase
    return cond[3] ? ~base : base;
  endfunction

  // FR load: single-cycle cc op in IDLE, or multi-cycle result arriving; never during reset
  always_comb begin
    w_fr_ld = 1'b0;
    if (reset_n) begin
      if (r_state == IDLE) w_fr_ld = bus.op_valid & bus.op_setcc & ~bus.op_multi;
      else                 w_fr_ld = bus.alu_done;
    end
  end

  assign w_cc_pending = (r_state == WAIT_ALU) | w_fr_ld;

`ifdef ICC_FORWARD_EN
  // A load in this cycle is forwarded straight into the evaluation
  assign w_br_accept  = reset_n & bus.br_req & ~r_br_ack & (~w_cc_pending | w_fr_ld);
  assign w_eval_flags = w_fr_ld ? bus.alu_flags : bus.fr_flags;
`else
  // Branch waits until no flag write is outstanding
  assign w_br_accept  = reset_n & bus.br_req & ~r_br_ack & ~w_cc_pending;
  assign w_eval_flags = bus.fr_flags;
`endif

  assign w_cond_true = cond_eval(bus.br_cond, w_eval_flags);

  // Controller FSM, wait timer and registered branch/timeout outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_wait_cnt   <= 8'd0;
      r_br_ack     <= 1'b0;
      r_br_taken   <= 1'b0;
      r_cc_timeout <= 1'b0;
    end else begin
      r_cc_timeout <= 1'b0;
      r_br_ack     <= w_br_accept;
      if (w_br_accept) r_br_taken <= w_cond_true;
      case (r_state)
        IDLE: begin
          if (bus.op_valid && bus.op_setcc && bus.op_multi) begin
            r_state    <= WAIT_ALU;
            r_wait_cnt <= 8'd0;
          end
        end
        WAIT_ALU: begin
          // alu_done on the final wait cycle takes priority over abandonment
          if (bus.alu_done) begin
            r_state <= IDLE;
          end else if (r_wait_cnt == LAST_WAIT) begin
            r_state      <= IDLE;
            r_cc_timeout <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.op_ready     = (r_state == IDLE);
  assign bus.fr_ld        = w_fr_ld;
  assign bus.cc_pending   = w_cc_pending;
  assign bus.br_ack       = r_br_ack;
  assign bus.br_taken     = r_br_taken;
  assign bus.stall        = bus.br_req & ~w_br_accept;
  assign bus.cc_timeout   = r_cc_timeout;
  assign bus.dbg_state    = r_state;
  assign bus.dbg_wait_cnt = r_wait_cnt;

endmodule

// File: tb/tb_icc_ctrl.sv
// tb_icc_ctrl: directed and randomized checks of icc_ctrl. Two instances share
// the stimulus: u_dut with the default MAX_WAIT (15) and u_dut4 with MAX_WAIT=4.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_icc_ctrl;

`ifdef ICC_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int MW  = 15;
  localparam int MW4 = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       op_valid = 1'b0, op_setcc = 1'b0, op_multi = 1'b0;
  logic       alu_done = 1'b0, br_req = 1'b0;
  logic [3:0] alu_flags = 4'h0, br_cond = 4'h0;
  logic [3:0] fr_q = 4'h0;   // the flag register FR itself

  int n_checks = 0;
  int n_err    = 0;

  icc_ctrl_if u_if ();
  icc_ctrl_if u_if4 ();

  assign u_if.op_valid   = op_valid;   assign u_if4.op_valid  = op_valid;
  assign u_if.op_setcc   = op_setcc;   assign u_if4.op_setcc  = op_setcc;
  assign u_if.op_multi   = op_multi;   assign u_if4.op_multi  = op_multi;
  assign u_if.alu_done   = alu_done;   assign u_if4.alu_done  = alu_done;
  assign u_if.alu_flags  = alu_flags;  assign u_if4.alu_flags = alu_flags;
  assign u_if.fr_flags   = fr_q;       assign u_if4.fr_flags  = fr_q;
  assign u_if.br_req     = br_req;     assign u_if4.br_req    = br_req;
  assign u_if.br_cond    = br_cond;    assign u_if4.br_cond   = br_cond;

  icc_ctrl u_dut (.clk(clk), .reset_n(rst_n), .bus(u_if.slave));
  icc_ctrl #(.MAX_WAIT(MW4)) u_dut4 (.clk(clk), .reset_n(rst_n), .bus(u_if4.slave));

  // FR captures alu_flags when the controller commands a load
  always @(posedge clk) if (u_if.fr_ld === 1'b1) fr_q <= alu_flags;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference Bicc table, written entry by entry from the condition list
  function automatic logic ref_cond(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, v, c;
    {n, z, v, c} = f;
    case (cond)
      4'b1000: return 1'b1;           4'b0000: return 1'b0;
      4'b1001: return !z;             4'b0001: return z;
      4'b1010: return !(z | (n ^ v)); 4'b0010: return z | (n ^ v);
      4'b1011: return !(n ^ v);       4'b0011: return n ^ v;
      4'b1100: return !(c | z);       4'b0100: return c | z;
      4'b1101: return !c;             4'b0101: return c;
      4'b1110: return !n;             4'b0110: return n;
      4'b1111: return !v;             default: return v;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic nc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    op_valid = 1'b0; op_setcc = 1'b0; op_multi = 1'b0;
    alu_done = 1'b0; br_req = 1'b0; br_cond = 4'h0; alu_flags = 4'h0;
  endtask

  task automatic send_op(input logic multi, input logic [3:0] flags);
    op_valid = 1'b1; op_setcc = 1'b1; op_multi = multi; alu_flags = flags;
  endtask

  // random-phase model variables
  bit       m_wait, m_ack, m_taken, m_tmo;
  int       m_start;
  bit       e_ld, e_pend, e_acc;
  logic [3:0] fv_tab [4];
  logic [3:0] keep_fr;

  initial begin
    fv_tab[0] = 4'h0; fv_tab[1] = 4'h5; fv_tab[2] = 4'hA; fv_tab[3] = 4'hF;

    // ---- reset values, with op_valid and br_req asserted during reset ----
    #2 rst_n = 1'b0;
    nc(); br_req = 1'b1; br_cond = 4'b1000; send_op(1'b0, 4'h3); #1;
    chk("rst_fr_ld",    u_if.fr_ld, 0);
    chk("rst_pending",  u_if.cc_pending, 0);
    chk("rst_op_ready", u_if.op_ready, 1);
    chk("rst_stall",    u_if.stall, 1);
    chk("rst_br_ack",   u_if.br_ack, 0);
    chk("rst_br_taken", u_if.br_taken, 0);
    chk("rst_timeout",  u_if.cc_timeout, 0);
    nc(); rst_n = 1'b1; idle_inputs(); #1;
    chk("rst_rel_ack", u_if.br_ack, 0);
    chk("rst_fr_kept", fr_q, 4'h0);

    // ---- reset in the middle of WAIT_ALU ----
    nc(); send_op(1'b1, 4'h0); #1;
    chk("a_ready_idle", u_if.op_ready, 1);
    chk("a_no_ld",      u_if.fr_ld, 0);
    nc(); idle_inputs(); #1;
    chk("a_pending", u_if.cc_pending, 1);
    chk("a_busy",    u_if.op_ready, 0);
    nc(); #2; rst_n = 1'b0; send_op(1'b0, 4'h7); #1;
    chk("a_rst_ld",    u_if.fr_ld, 0);
    chk("a_rst_ready", u_if.op_ready, 1);
    chk("a_rst_pend",  u_if.cc_pending, 0);
    nc(); #1;
    chk("a_rst_ld2", u_if.fr_ld, 0);
    nc(); rst_n = 1'b1; idle_inputs(); #1;
    chk("a_rel_ready", u_if.op_ready, 1);
    chk("a_rel_tmo",   u_if.cc_timeout, 0);
    for (int i = 0; i < 17; i++) begin
      nc(); #1;
      chk("a_no_tmo",  u_if.cc_timeout, 0);
      chk("a_no_tmo4", u_if4.cc_timeout, 0);
    end
    chk("a_fr_unloaded", fr_q, 4'h0);

    // ---- single-cycle SUBcc (Z) with a simultaneous BE ----
    nc(); send_op(1'b0, 4'b0100); br_req = 1'b1; br_cond = 4'b0001; #1;
    chk("b_fr_ld", u_if.fr_ld, 1);
    chk("b_pend",  u_if.cc_pending, 1);
    chk("b_stall0", u_if.stall, FWD ? 0 : 1);
    nc(); op_valid = 1'b0; op_setcc = 1'b0;
    if (FWD) br_req = 1'b0;
    #1;
    chk("b_fr_loaded", fr_q, 4'b0100);
    chk("b_stall1",    u_if.stall, 0);
    chk("b_ack1",      u_if.br_ack, FWD ? 1 : 0);
    if (FWD) chk("b_taken_fwd", u_if.br_taken, 1);
    nc(); br_req = 1'b0; #1;
    chk("b_ack2", u_if.br_ack, FWD ? 0 : 1);
    if (!FWD) chk("b_taken", u_if.br_taken, 1);
    nc(); #1;
    chk("b_ack3", u_if.br_ack, 0);

    // ---- multi-cycle op, alu_done after 5 cycles, BL held ----
    nc(); send_op(1'b1, 4'h0); #1;
    chk("c_accept", u_if.op_ready, 1);
    for (int i = 1; i <= 5; i++) begin
      nc(); op_valid = 1'b0; op_setcc = 1'b0; op_multi = 1'b0;
      br_req = 1'b1; br_cond = 4'b0011;
      alu_done = (i == 5); alu_flags = (i == 5) ? 4'b1000 : 4'h0; #1;
      chk("c_pend",  u_if.cc_pending, 1);
      chk("c_ready", u_if.op_ready, 0);
      chk("c_stall", u_if.stall, (FWD && i == 5) ? 0 : 1);
      chk("c_ld",    u_if.fr_ld, (i == 5) ? 1 : 0);
    end
    nc(); alu_done = 1'b0; alu_flags = 4'h0;
    if (FWD) br_req = 1'b0;
    #1;
    chk("c_pend_clr", u_if.cc_pending, 0);
    chk("c_ack6", u_if.br_ack, FWD ? 1 : 0);
    if (FWD) chk("c_taken_fwd", u_if.br_taken, 1);
    if (!FWD) begin
      nc(); br_req = 1'b0; #1;
      chk("c_ack7",   u_if.br_ack, 1);
      chk("c_taken7", u_if.br_taken, 1);
    end

    // ---- timeout: no alu_done (MAX_WAIT=4 and default 15) ----
    nc(); idle_inputs(); #1;
    keep_fr = fr_q;
    nc(); send_op(1'b1, 4'hF); #1;
    for (int i = 1; i <= 17; i++) begin
      nc(); idle_inputs(); alu_flags = 4'hF; #1;
      chk("d_tmo4",   u_if4.cc_timeout, (i == MW4 + 1) ? 1 : 0);
      chk("d_ready4", u_if4.op_ready, (i > MW4) ? 1 : 0);
      chk("d_ld4",    u_if4.fr_ld, 0);
      chk("d_tmo",    u_if.cc_timeout, (i == MW + 1) ? 1 : 0);
      chk("d_ready",  u_if.op_ready, (i > MW) ? 1 : 0);
    end
    chk("d_fr_kept", fr_q, keep_fr);

    // ---- alu_done on the final wait cycle of the MAX_WAIT=4 instance ----
    nc(); send_op(1'b1, 4'h0); #1;
    for (int i = 1; i <= MW4; i++) begin
      nc(); idle_inputs(); alu_done = (i == MW4); alu_flags = 4'b0011; #1;
      chk("e_ld4", u_if4.fr_ld, (i == MW4) ? 1 : 0);
    end
    nc(); idle_inputs(); #1;
    chk("e_tmo4",   u_if4.cc_timeout, 0);
    chk("e_ready4", u_if4.op_ready, 1);
    chk("e_fr",     fr_q, 4'b0011);

    // ---- Bicc sweep against four FR values ----
    for (int k = 0; k < 4; k++) begin
      nc(); send_op(1'b0, fv_tab[k]); #1;
      nc(); idle_inputs(); #1;
      chk("f_fr", fr_q, fv_tab[k]);
      for (int cnd = 0; cnd < 16; cnd++) begin
        nc(); br_req = 1'b1; br_cond = 4'(cnd); #1;
        chk("f_req_ack", u_if.br_ack, 0);
        chk("f_req_stall", u_if.stall, 0);
        nc(); #1;   // request still held in the ack cycle
        chk("f_ack",   u_if.br_ack, 1);
        chk("f_stall", u_if.stall, 1);
        chk("f_taken", u_if.br_taken, ref_cond(4'(cnd), fv_tab[k]));
        nc(); br_req = 1'b0; #1;
        chk("f_ack_pulse", u_if.br_ack, 0);
      end
    end

    // ---- randomized traffic against the reference model ----
    nc(); rst_n = 1'b0; idle_inputs();
    nc(); rst_n = 1'b1;
    m_wait = 0; m_ack = 0; m_taken = 0; m_tmo = 0; m_start = 0;
    for (int t = 0; t < 400; t++) begin
      nc();
      if (m_ack) br_req = 1'b0;
      else if (!br_req && $urandom_range(0, 2) == 0) begin
        br_req = 1'b1; br_cond = 4'($urandom_range(0, 15));
      end
      op_valid  = 1'($urandom_range(0, 1));
      op_setcc  = ($urandom_range(0, 3) != 0);
      op_multi  = ($urandom_range(0, 2) == 0);
      alu_done  = ($urandom_range(0, 7) == 0);
      alu_flags = 4'($urandom_range(0, 15));
      #1;
      e_ld   = m_wait ? alu_done : (op_valid && op_setcc && !op_multi);
      e_pend = m_wait || e_ld;
      e_acc  = br_req && !m_ack && (FWD ? (!e_pend || e_ld) : !e_pend);
      chk("r_ready", u_if.op_ready, !m_wait);
      chk("r_fr_ld", u_if.fr_ld, e_ld);
      chk("r_pend",  u_if.cc_pending, e_pend);
      chk("r_stall", u_if.stall, br_req && !e_acc);
      chk("r_ack",   u_if.br_ack, m_ack);
      chk("r_tmo",   u_if.cc_timeout, m_tmo);
      if (m_ack) chk("r_taken", u_if.br_taken, m_taken);
      // advance the model: a multi-cycle op gets MW wait cycles counted from m_start
      m_tmo = m_wait && !alu_done && (t - m_start + 1 == MW);
      if (m_wait) m_wait = !(alu_done || m_tmo);
      else if (op_valid && op_setcc && op_multi) begin
        m_wait = 1; m_start = t + 1;
      end
      if (e_acc) m_taken = ref_cond(br_cond, (FWD && e_ld) ? alu_flags : fr_q);
      m_ack = e_acc;
    end

    // ---- final report ----
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
